serializer: RTL and testbench
=============================

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the parallel word width; legal values are powers of two, 4 to 64.
REQ-002 Parameter MOD_W, default $clog2(WIDTH), SHALL set the width of data_mod_i; it is derived and never overridden.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 srst_i  input  1  SHALL be the synchronous, active-low reset (0 = reset, sampled on the clk_i rising edge).
REQ-005 data_i  input  WIDTH  SHALL carry the parallel word to serialize; bit WIDTH-1 is sent first.
REQ-006 data_mod_i  input  MOD_W  SHALL give the number of bits N to send, taken from the MSB end; value 0 means N = WIDTH.
REQ-007 data_val_i  input  1  SHALL qualify data_i and data_mod_i as a transmit request.
REQ-008 ser_data_o  output  1  SHALL carry the current serial bit.
REQ-009 ser_data_val_o  output  1  SHALL be high in every cycle that ser_data_o carries a valid bit.
REQ-010 busy_o  output  1  SHALL be high while a word is being transmitted; requests made while it is high are not accepted.

Function
REQ-011 The block SHALL implement two states, IDLE and SEND; reset enters IDLE.
REQ-012 A request SHALL be accepted on a rising edge where srst_i=1, state=IDLE and data_val_i=1, and data_mod_i is not 1 or 2.
REQ-013 On acceptance, data_i and the effective N SHALL be captured into internal registers, and the state SHALL go to SEND.
REQ-014 Requests with data_mod_i = 1 or 2 SHALL be dropped silently; state remains IDLE and no output changes.
REQ-015 Latency: the first bit (data_i[WIDTH-1]) SHALL appear on ser_data_o, with ser_data_val_o=1, in the cycle immediately after the accepting edge.
REQ-016 Bits data_i[WIDTH-1] down to data_i[WIDTH-N] SHALL be output MSB-first on N consecutive cycles, with no gaps.
REQ-017 busy_o SHALL equal ser_data_val_o: high for exactly those N cycles, low otherwise.
REQ-018 After the edge ending the Nth bit, the state SHALL return to IDLE, and busy_o and ser_data_val_o SHALL drop to 0.
REQ-019 The earliest next acceptance SHALL be on the edge ending the first IDLE cycle, which gives one idle cycle between words.
REQ-020 data_val_i, data_i and data_mod_i SHALL be ignored while in SEND; captured values SHALL NOT change mid-word.
REQ-021 ser_data_o SHALL be 0 whenever ser_data_val_o is 0.
REQ-022 The bit counter SHALL be MOD_W+1 bits wide so that N = WIDTH is counted without wrap-around.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 With srst_i=0 at a rising edge, the next state SHALL be IDLE, and ser_data_o=0, ser_data_val_o=0 and busy_o=0.
REQ-025 Reset asserted mid-word SHALL abort the transfer on that edge; no further bits are output, and the remaining captured data is discarded.
REQ-026 Reset SHALL take priority over a simultaneous data_val_i; that request is not accepted.
REQ-027 The first request accepted after reset release SHALL behave identically to REQ-015 to REQ-018.

Verification
REQ-028 Full word: data_i=16'hA5C3, data_mod_i=0, 1-cycle data_val_i -> 16 valid cycles, serial 1010_0101_1100_0011, busy_o high for 16 cycles.
REQ-029 Partial word: data_i=16'hF000, data_mod_i=5 -> 5 valid cycles, serial 1,1,1,1,0, then ser_data_val_o=0.
REQ-030 Illegal length: data_mod_i=1, then data_mod_i=2, each with data_val_i=1 -> no ser_data_val_o, busy_o stays 0.
REQ-031 Busy request: second request (16'hFFFF, mod 0) during bit 3 of 16'h0000 -> output stays 16 zeros, and the second word is never sent.
REQ-032 Reset mid-word: srst_i=0 for one edge during bit 8 of 16'hFFFF -> outputs 0 in the next cycle, and no further valid bits.
REQ-033 Back-to-back: data_val_i held high with 16'h8001 mod 0 -> 16 bits, 1 idle cycle, 16 bits, repeating; a bench-side deserializer model reconstructs 16'h8001 every word.

Source files
------------

// File: rtl/serializer.sv
// MSB-first parallel-to-serial converter with a per-word length of N bits
// taken from the top of data_i. Lengths 1 and 2 are rejected.
module serializer #(
  parameter int WIDTH = 16,
  parameter int MOD_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  localparam int CNT_W = MOD_W + 1;
  localparam logic [CNT_W-1:0] FULL_N = CNT_W'(WIDTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic [CNT_W-1:0] req_len;
  logic             req_legal;

  // A length field of zero selects the full word.
  always_comb begin
    req_len   = (data_mod_i == '0) ? FULL_N : {1'b0, data_mod_i};
    req_legal = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));
  end

  // remaining_reg counts the bits still to follow the one currently on ser_data_o.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      remaining_reg  <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (data_val_i && req_legal) begin
            state_reg      <= SEND;
            shift_reg      <= {data_i[WIDTH-2:0], 1'b0};
            remaining_reg  <= req_len - CNT_W'(1);
            ser_data_o     <= data_i[WIDTH-1];
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end
        SEND: begin
          if (remaining_reg == '0) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
          end else begin
            shift_reg     <= {shift_reg[WIDTH-2:0], 1'b0};
            remaining_reg <= remaining_reg - CNT_W'(1);
            ser_data_o    <= shift_reg[WIDTH-1];
          end
        end
        default: begin
          state_reg      <= IDLE;
          ser_data_o     <= 1'b0;
          ser_data_val_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: vector table, directed multi-cycle sequences and
// random traffic, all checked against a queue-based bit-stream model.
module tb_serializer;

  localparam int W  = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          dval;
  logic [W-1:0]  data;
  logic [MW-1:0] dmod;
  logic          sd;
  logic          sv;
  logic          busy;

  int tests = 0;
  int fails = 0;

  // Model: queue of bits still to appear; head is the bit currently shown.
  bit model_q[$];

  // Bench-side deserializer
  logic [W-1:0] words[$];
  int           counts[$];
  logic [W-1:0] rx_word = '0;
  int           rx_cnt = 0;
  int           busy_cycles = 0;

  always #5 clk = ~clk;

  serializer #(.WIDTH(W)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (data),
    .data_mod_i     (dmod),
    .data_val_i     (dval),
    .ser_data_o     (sd),
    .ser_data_val_o (sv),
    .busy_o         (busy)
  );

  typedef struct {
    logic          srst;
    logic          val;
    logic [W-1:0]  data;
    logic [MW-1:0] mod;
    logic          exp_val;
    logic          exp_bit;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [W-1:0] d,
                            input logic [MW-1:0] m);
    int n;
    if (!s) begin
      model_q.delete();
    end else if (model_q.size() > 0) begin
      void'(model_q.pop_front());
    end else if (v && m != 1 && m != 2) begin
      n = (m == 0) ? W : int'(m);
      for (int i = 0; i < n; i++) model_q.push_back(d[W-1-i]);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [W-1:0] d,
                      input logic [MW-1:0] m);
    logic ev;
    logic eb;
    srst = s;
    dval = v;
    data = d;
    dmod = m;
    @(posedge clk);
    #1;
    model_edge(s, v, d, m);
    ev = (model_q.size() > 0);
    eb = ev ? model_q[0] : 1'b0;
    chk("model {val,bit,busy}", {61'd0, sv, sd, busy}, {61'd0, ev, eb, ev});
    if (busy) busy_cycles++;
    if (sv) begin
      rx_word = {rx_word[W-2:0], sd};
      rx_cnt++;
    end else if (rx_cnt != 0) begin
      words.push_back(rx_word);
      counts.push_back(rx_cnt);
      rx_word = '0;
      rx_cnt  = 0;
    end
    $display("[TB] t=%0t srst=%0b val=%0b data=%h mod=%0d -> ser=%0b sval=%0b busy=%0b",
             $time, s, v, d, m, sd, sv, busy);
  endtask

  task automatic clear_rx();
    words.delete();
    counts.delete();
    busy_cycles = 0;
  endtask

  initial begin
    srst = 1'b0;
    dval = 1'b0;
    data = '0;
    dmod = '0;

    // Reset priority, illegal lengths, partial word, mid-word ignore, idle gap
    tbl[0]  = '{1'b0, 1'b1, 16'hFFFF, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'hFFFF, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'hFFFF, 4'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'hFFFF, 4'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 16'hF000, 4'd5, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 16'h0000, 4'd0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 16'hFFFF, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 16'h8000, 4'd3, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].srst, tbl[i].val, tbl[i].data, tbl[i].mod);
      chk($sformatf("vec%0d", i), {61'd0, sv, sd, busy},
          {61'd0, tbl[i].exp_val, tbl[i].exp_bit, tbl[i].exp_val});
    end

    // Full word A5C3
    clear_rx();
    step(1'b1, 1'b1, 16'hA5C3, 4'd0);
    repeat (18) step(1'b1, 1'b0, 16'h0000, 4'd0);
    chk("full_words", 64'(words.size()), 64'd1);
    if (words.size() > 0) begin
      chk("full_data", 64'(words[0]), 64'hA5C3);
      chk("full_len", 64'(counts[0]), 64'd16);
    end
    chk("full_busy_cycles", 64'(busy_cycles), 64'd16);

    // Request during bit 3 of a zero word is dropped
    clear_rx();
    step(1'b1, 1'b1, 16'h0000, 4'd0);
    step(1'b1, 1'b0, 16'h0000, 4'd0);
    step(1'b1, 1'b0, 16'h0000, 4'd0);
    step(1'b1, 1'b1, 16'hFFFF, 4'd0);
    repeat (30) step(1'b1, 1'b0, 16'h0000, 4'd0);
    chk("busy_words", 64'(words.size()), 64'd1);
    if (words.size() > 0) begin
      chk("busy_data", 64'(words[0]), 64'h0000);
      chk("busy_len", 64'(counts[0]), 64'd16);
    end

    // Reset on the edge ending the 8th bit of FFFF
    clear_rx();
    step(1'b1, 1'b1, 16'hFFFF, 4'd0);
    repeat (7) step(1'b1, 1'b0, 16'h0000, 4'd0);
    step(1'b0, 1'b0, 16'h0000, 4'd0);
    chk("rst_mid_out", {62'd0, sv, busy}, 64'd0);
    repeat (20) step(1'b1, 1'b0, 16'h0000, 4'd0);
    chk("rst_words", 64'(words.size()), 64'd1);
    if (words.size() > 0) chk("rst_len", 64'(counts[0]), 64'd8);

    // Back-to-back with data_val held high
    clear_rx();
    repeat (68) step(1'b1, 1'b1, 16'h8001, 4'd0);
    repeat (3) step(1'b1, 1'b0, 16'h0000, 4'd0);
    chk("b2b_words", 64'(words.size()), 64'd4);
    for (int i = 0; i < words.size(); i++) begin
      chk($sformatf("b2b_data%0d", i), 64'(words[i]), 64'h8001);
      chk($sformatf("b2b_len%0d", i), 64'(counts[i]), 64'd16);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
           W'($urandom), MW'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
